stage_ctrl_multi: RTL

- Parametrised game-stage controller. It sequences MENU -> SYNC -> GAME -> OVER for one local board linked to NPEER remote boards over level-signalled connect/start/finish wires.
- Supersedes the single-peer stage FSM. New behaviour: a start-acknowledge sync phase with timeout, connect/disconnect toggling, per-peer link masks, and reporting of which side finished the game.
- Sits between the mouse/button hit-test logic and the game core and peer I/O pins.

---
 rtl/stage_ctrl_multi.sv | 134 +++++++++++++
 1 files changed

// File: rtl/stage_ctrl_multi.sv
// stage_ctrl_multi: MENU/SYNC/GAME/OVER stage controller for one local board and NPEER remote peers
module stage_ctrl_multi #(
   parameter int NPEER       = 1,
   parameter int TIMEOUT_CYC = 50000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mouse_left,
   input  logic             on_start_btn,
   input  logic             on_connect_btn,
   input  logic             on_return_btn,
   input  logic             game_finish,
   input  logic [NPEER-1:0] rx_connect,
   input  logic [NPEER-1:0] rx_start,
   input  logic [NPEER-1:0] rx_finish,
   output logic             tx_connect,
   output logic             tx_start,
   output logic             tx_finish,
   output logic [NPEER-1:0] linked,
   output logic             role,
   output logic [1:0]       state,
   output logic             game_init,
   output logic             finish_src,
   output logic             sync_timeout
);
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic MASTER = 1'b0;
   localparam logic SLAVE  = 1'b1;
   typedef enum logic [1:0] {MENU = 2'd0, SYNC = 2'd1, GAME = 2'd2, OVER = 2'd3} state_t;
   state_t        state_q, state_d;
   logic          tx_connect_q, tx_connect_d;
   logic          tx_start_q, tx_start_d;
   logic          tx_finish_q, tx_finish_d;
   logic          role_q, role_d;
   logic          finish_src_q, finish_src_d;
   logic          sync_timeout_q, sync_timeout_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          mouse_left_q;
   logic          click;
   assign click        = mouse_left_q & ~mouse_left;
   assign linked       = rx_connect & {NPEER{tx_connect_q}};
   assign tx_connect   = tx_connect_q;
   assign tx_start     = tx_start_q;
   assign tx_finish    = tx_finish_q;
   assign role         = role_q;
   assign state        = state_q;
   assign game_init    = state_q != GAME;
   assign finish_src   = finish_src_q;
   assign sync_timeout = sync_timeout_q;
   // state and output registers; reset returns everything to MENU / idle
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= MENU;
         tx_connect_q   <= 1'b0;
         tx_start_q     <= 1'b0;
         tx_finish_q    <= 1'b0;
         role_q         <= MASTER;
         finish_src_q   <= 1'b0;
         sync_timeout_q <= 1'b0;
         timer_q        <= '0;
         mouse_left_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         tx_connect_q   <= tx_connect_d;
         tx_start_q     <= tx_start_d;
         tx_finish_q    <= tx_finish_d;
         role_q         <= role_d;
         finish_src_q   <= finish_src_d;
         sync_timeout_q <= sync_timeout_d;
         timer_q        <= timer_d;
         mouse_left_q   <= mouse_left;
      end
   end
   // next-state: button clicks act on release; SYNC waits for all linked peers to ack or times out
   always_comb begin
      state_d        = state_q;
      tx_connect_d   = tx_connect_q;
      tx_start_d     = tx_start_q;
      tx_finish_d    = tx_finish_q;
      role_d         = role_q;
      finish_src_d   = finish_src_q;
      sync_timeout_d = 1'b0;
      timer_d        = timer_q;
      case (state_q)
         MENU: begin
            tx_finish_d = 1'b0;
            if (click && on_connect_btn) begin
               tx_connect_d = ~tx_connect_q;
               role_d       = tx_connect_q ? MASTER : (|rx_connect ? SLAVE : MASTER);
            end
            if (role_q == SLAVE) begin
               if (|(rx_start & linked)) begin
                  state_d    = GAME;
                  tx_start_d = 1'b1;
               end
            end else if (click && on_start_btn) begin
               tx_start_d = 1'b1;
               state_d    = (linked == '0) ? GAME : SYNC;
               timer_d    = (linked == '0) ? timer_q : TW'(TIMEOUT_CYC - 1);
            end
         end
         SYNC: begin
            if ((rx_start & linked) == linked) begin
               state_d = GAME;
            end else if (timer_q == '0) begin
               state_d        = MENU;
               tx_start_d     = 1'b0;
               sync_timeout_d = 1'b1;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         GAME: begin
            if (game_finish) begin
               state_d      = OVER;
               tx_start_d   = 1'b0;
               tx_finish_d  = 1'b1;
               finish_src_d = 1'b0;
            end else if (|(rx_finish & linked)) begin
               state_d      = OVER;
               tx_start_d   = 1'b0;
               finish_src_d = 1'b1;
            end
         end
         default: begin
            tx_start_d = 1'b0;
            if (click && on_return_btn) begin
               state_d     = MENU;
               tx_finish_d = 1'b0;
            end
         end
      endcase
   end
endmodule
